// File: rtl/migu_alu_seq.sv
// Sequential MigU ALU: single-cycle ops with a one-entry registered result and an iterative
// shift-add multiplier. Valid/ready handshakes on both sides; one operation in flight at a time.
module migu_alu_seq #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned MUL_STEP  = 1,
    parameter int unsigned CMD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kill,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 co,
    output logic                 err
);

    localparam int unsigned N_MUL = WIDTH / MUL_STEP;
    localparam int unsigned CNT_W = (N_MUL > 1) ? $clog2(N_MUL) : 1;
    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_MUL - 1);

    localparam logic [CMD_WIDTH-1:0] CMD_ADD  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_SUB  = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_AND  = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_OR   = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] CMD_XOR  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] CMD_SLL  = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] CMD_SRL  = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] CMD_SRA  = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] CMD_SLT  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] CMD_SLTU = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] CMD_MUL  = CMD_WIDTH'(10);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_d;
    logic             rst_done;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] acc, acc_d, mcand, mcand_d, mplier, mplier_d;
    logic             out_valid_d, co_d, err_d;
    logic [WIDTH-1:0] out_d;

    logic             is_sub;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res, pp_sum;
    logic             alu_co, alu_err;

    // rst_done holds in_ready low until the first edge after reset release
    assign in_ready = rst_done && (state == IDLE) && (!out_valid || out_ready);

    // Single-cycle datapath; SUB reuses the adder as in1 + ~in2 + 1
    always_comb begin
        is_sub  = (cmd == CMD_SUB);
        shamt   = in2[SH_W-1:0];
        sum     = {1'b0, in1} + {1'b0, (is_sub ? ~in2 : in2)} + SUM_W'(is_sub);
        alu_res = '0;
        alu_co  = 1'b0;
        alu_err = 1'b0;
        case (cmd)
            CMD_ADD, CMD_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
            end
            CMD_AND:  alu_res = in1 & in2;
            CMD_OR:   alu_res = in1 | in2;
            CMD_XOR:  alu_res = in1 ^ in2;
            CMD_SLL:  alu_res = in1 << shamt;
            CMD_SRL:  alu_res = in1 >> shamt;
            CMD_SRA:  alu_res = $signed(in1) >>> shamt;
            CMD_SLT:  alu_res = WIDTH'($signed(in1) < $signed(in2));
            CMD_SLTU: alu_res = WIDTH'(in1 < in2);
            CMD_MUL:  alu_res = '0;
            default:  alu_err = 1'b1;
        endcase
    end

    // MUL_STEP partial products retired per BUSY cycle
    always_comb begin
        pp_sum = acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) pp_sum = pp_sum + (mcand << j);
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        acc_d       = acc;
        mcand_d     = mcand;
        mplier_d    = mplier;
        out_valid_d = out_valid;
        out_d       = out;
        co_d        = co;
        err_d       = err;

        if (out_valid && out_ready) out_valid_d = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (cmd == CMD_MUL) begin
                        state_d  = BUSY;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = in1;
                        mplier_d = in2;
                    end else begin
                        out_valid_d = 1'b1;
                        out_d       = alu_res;
                        co_d        = alu_co;
                        err_d       = alu_err;
                    end
                end
            end
            BUSY: begin
                acc_d    = pp_sum;
                mcand_d  = mcand << MUL_STEP;
                mplier_d = mplier >> MUL_STEP;
                cnt_d    = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_d       = pp_sum;
                    co_d        = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // kill beats any accept or completion on the same edge; out/co left as they were
        if (kill) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
            out_d       = out;
            co_d        = co;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rst_done  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            co        <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            rst_done  <= 1'b1;
            cnt       <= cnt_d;
            acc       <= acc_d;
            mcand     <= mcand_d;
            mplier    <= mplier_d;
            out_valid <= out_valid_d;
            out       <= out_d;
            co        <= co_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_migu_alu_seq.sv
// Self-checking bench for migu_alu_seq: directed scenarios plus randomized traffic
// scored against a plain-arithmetic reference model.
module tb_migu_alu_seq;

    typedef struct packed {
        logic [63:0] out;
        logic        co;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill, in_valid, in_valid4, out_ready;
    logic [3:0]  cmd;
    logic [63:0] in1, in2;
    logic        in_ready, out_valid, co, err;
    logic [63:0] out;
    logic        in_ready4, out_valid4, co4, err4;
    logic [63:0] out4;
    logic        sel4;
    logic        rdy_m, vld_m;
    logic [63:0] out_m;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    migu_alu_seq #(.WIDTH(64), .MUL_STEP(1), .CMD_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .co(co), .err(err)
    );

    migu_alu_seq #(.WIDTH(64), .MUL_STEP(4), .CMD_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .kill(kill), .in_valid(in_valid4), .in_ready(in_ready4),
        .cmd(cmd), .in1(in1), .in2(in2), .out_valid(out_valid4), .out_ready(out_ready),
        .out(out4), .co(co4), .err(err4)
    );

    assign rdy_m = sel4 ? in_ready4  : in_ready;
    assign vld_m = sel4 ? out_valid4 : out_valid;
    assign out_m = sel4 ? out4       : out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    // Reference: results from the arithmetic definition of each command
    function automatic res_t model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        res_t        r;
        logic [64:0] wide;
        int          sh;
        r  = '0;
        sh = int'(b[5:0]);
        case (c)
            4'd0: begin wide = {1'b0, a} + {1'b0, b}; r.out = wide[63:0]; r.co = wide[64]; end
            4'd1: begin r.out = a - b; r.co = (a >= b); end
            4'd2: r.out = a & b;
            4'd3: r.out = a | b;
            4'd4: r.out = a ^ b;
            4'd5: r.out = a << sh;
            4'd6: r.out = a >> sh;
            4'd7: begin
                r.out = a >> sh;
                for (int i = 0; i < sh; i++) r.out[63-i] = a[63];
            end
            4'd8: r.out = {63'd0, (a[63] != b[63]) ? a[63] : (a < b)};
            4'd9: r.out = {63'd0, (a < b)};
            4'd10: r.out = a * b;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Drive one request on the selected DUT; returns the cycle count seen just before the accept edge
    task automatic send(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                        output int acc_cyc, output bit ok);
        @(posedge clk); #1;
        if (sel4) in_valid4 = 1'b1; else in_valid = 1'b1;
        cmd = c; in1 = a; in2 = b;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rdy_m) begin ok = 1'b1; break; end
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
    endtask

    task automatic wait_out(output int vcyc, output int busy, output bit ok);
        ok = 1'b0; busy = 0; vcyc = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (vld_m) begin ok = 1'b1; vcyc = cyc; break; end
            if (!rdy_m) busy++;
        end
    endtask

    task automatic test_reset();
        int c0, v, b; bit ok, okw;
        @(posedge clk); @(posedge clk); @(negedge clk);
        tests++;
        if ({out_valid, out, co, err, in_ready} !== 68'd0) begin
            fails++; $display("FAIL reset_state: got v=%b out=%h co=%b err=%b rdy=%b required all 0",
                              out_valid, out, co, err, in_ready);
        end
        rst = 1'b0; #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_release_rdy: got %b required 0", in_ready); end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_first_edge_rdy: got %b required 1", in_ready); end

        // reset in the middle of a multiply
        send(4'd10, 64'h1234_5678_9ABC_DEF1, 64'h0FED_CBA9_8765_4321, c0, ok);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({ok, out_valid, in_ready} !== 3'b100) begin
            fails++; $display("FAIL reset_mid_mul: got acc=%b v=%b rdy=%b required 1 0 0", ok, out_valid, in_ready);
        end
        @(negedge clk); rst = 1'b0; #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_mid_release_rdy: got %b required 0", in_ready); end
        @(negedge clk);
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++; $display("FAIL reset_mid_after_edge: got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        send(4'd0, 64'd1, 64'd1, c0, ok);
        wait_out(v, b, okw);
        tests++;
        if ({ok, okw, out, co, err} !== {2'b11, 64'd2, 2'b00}) begin
            fails++; $display("FAIL reset_then_add: got ok=%b%b out=%h co=%b err=%b required 11 2 0 0",
                              ok, okw, out, co, err);
        end
    endtask

    task automatic test_add_sub();
        int c0, v, b; bit ok, okw;
        out_ready = 1'b1;
        send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, c0, ok);
        wait_out(v, b, okw);
        tests++;
        if ({ok, okw, out, co, err} !== {2'b11, 64'd0, 2'b10} || v !== c0 + 1) begin
            fails++; $display("FAIL add_wrap: got out=%h co=%b err=%b lat=%0d required 0 1 0 lat 1",
                              out, co, err, v - c0);
        end
        send(4'd1, 64'd5, 64'd7, c0, ok);
        wait_out(v, b, okw);
        tests++;
        if ({ok, okw, out, co, err} !== {2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00} || v !== c0 + 1) begin
            fails++; $display("FAIL sub_borrow: got out=%h co=%b err=%b lat=%0d required fffffffffffffffe 0 0 lat 1",
                              out, co, err, v - c0);
        end
    endtask

    task automatic test_mul(input bit s);
        int c0, v, b, n; bit ok, okw;
        sel4 = s;
        n = s ? 16 : 64;
        out_ready = 1'b1;
        send(4'd10, 64'h1_0000_0003, 64'h5, c0, ok);
        wait_out(v, b, okw);
        tests++;
        if ({ok, okw, out_m} !== {2'b11, 64'h5_0000_000F} || v !== c0 + 1 + n || b !== n) begin
            fails++; $display("FAIL mul_step%0d: got out=%h edges=%0d busy=%0d required 500000000f edges %0d busy %0d",
                              s ? 4 : 1, out_m, v - c0 - 1, b, n, n);
        end
        tests++;
        if ((s ? {co4, err4} : {co, err}) !== 2'b00) begin
            fails++; $display("FAIL mul_flags_step%0d: got co/err=%b required 00", s ? 4 : 1, s ? {co4, err4} : {co, err});
        end
        @(negedge clk);
        sel4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a[3], b[3];
        res_t e[3];
        for (int i = 0; i < 3; i++) begin
            a[i] = {$urandom, $urandom}; b[i] = {$urandom, $urandom};
            e[i] = model(4'd4, a[i], b[i]);
        end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; cmd = 4'd4; in1 = a[0]; in2 = b[0];
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_first_rdy: got %b required 1", in_ready); end
        @(posedge clk); #1;
        in1 = a[1]; in2 = b[1];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, out, co, err} !== {2'b10, e[0].out, 2'b00}) begin
                fails++; $display("FAIL b2b_hold%0d: got v=%b rdy=%b out=%h required 1 0 %h", k,
                                  out_valid, in_ready, out, e[0].out);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, in_ready, out} !== {2'b11, e[0].out}) begin
            fails++; $display("FAIL b2b_res0: got v=%b rdy=%b out=%h required 1 1 %h", out_valid, in_ready, out, e[0].out);
        end
        @(posedge clk); #1;
        in1 = a[2]; in2 = b[2];
        @(negedge clk);
        tests++;
        if ({out_valid, in_ready, out} !== {2'b11, e[1].out}) begin
            fails++; $display("FAIL b2b_res1: got v=%b rdy=%b out=%h required 1 1 %h", out_valid, in_ready, out, e[1].out);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, out} !== {1'b1, e[2].out}) begin
            fails++; $display("FAIL b2b_res2: got v=%b out=%h required 1 %h", out_valid, out, e[2].out);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_dup: got v=%b required 0", out_valid); end
    endtask

    task automatic test_illegal();
        int c0, v, b; bit ok, okw;
        out_ready = 1'b1;
        send(4'hC, {$urandom, $urandom}, {$urandom, $urandom}, c0, ok);
        wait_out(v, b, okw);
        tests++;
        if ({ok, okw, out, co, err} !== {2'b11, 64'd0, 2'b01}) begin
            fails++; $display("FAIL illegal_cmd: got out=%h co=%b err=%b required 0 0 1", out, co, err);
        end
        send(4'd7, 64'h8000_0000_0000_0000, 64'd63, c0, ok);
        wait_out(v, b, okw);
        tests++;
        if ({ok, okw, out, co, err} !== {2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00}) begin
            fails++; $display("FAIL sra_after_illegal: got out=%h co=%b err=%b required ffffffffffffffff 0 0", out, co, err);
        end
    endtask

    task automatic test_kill();
        int c0; bit ok, seen;
        out_ready = 1'b1;
        send(4'd10, {$urandom, $urandom}, {$urandom, $urandom}, c0, ok);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1; in_valid = 1'b1; cmd = 4'd0; in1 = 64'd1; in2 = 64'd1;
        @(negedge clk);
        tests++;
        if ({ok, in_ready} !== 2'b10) begin fails++; $display("FAIL kill_busy_rdy: got acc=%b rdy=%b required 1 0", ok, in_ready); end
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++; $display("FAIL kill_busy_after: got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        seen = 1'b0;
        for (int n = 0; n < 80; n++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL kill_no_result: got out_valid seen=%b required 0", seen); end

        // kill on the same edge as an accept in IDLE
        @(posedge clk); #1;
        kill = 1'b1; in_valid = 1'b1; cmd = 4'd0; in1 = 64'd5; in2 = 64'd6;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL kill_accept_rdy: got %b required 1", in_ready); end
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL kill_wins_accept: got v=%b required 0", out_valid); end

        // kill clears a pending error result
        out_ready = 1'b0;
        send(4'hF, 64'd3, 64'd4, c0, ok);
        @(negedge clk);
        tests++;
        if ({ok, out_valid, err, out} !== {3'b111, 64'd0}) begin
            fails++; $display("FAIL kill_pending_err: got v=%b err=%b out=%h required 1 1 0", out_valid, err, out);
        end
        @(posedge clk); #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, err, in_ready} !== 3'b001) begin
            fails++; $display("FAIL kill_clears_err: got v=%b err=%b rdy=%b required 0 0 1", out_valid, err, in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        res_t q[$];
        res_t e;
        logic [65:0] held;
        bit hold, accepted;
        int outs;
        hold = 1'b0; outs = 0;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (hold) begin
                tests++;
                if ({out_valid, out, co, err} !== {1'b1, held}) begin
                    fails++; $display("FAIL rnd_stable@%0d: got v=%b out=%h required 1 %h", cyc, out_valid, out, held[65:2]);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rnd_spurious@%0d: got out=%h required no result", cyc, out);
                end else begin
                    e = q.pop_front();
                    outs++;
                    if ({out, co, err} !== e) begin
                        fails++; $display("FAIL rnd_result@%0d: got out=%h co=%b err=%b required %h %b %b",
                                          cyc, out, co, err, e.out, e.co, e.err);
                    end
                end
            end
            hold = out_valid && !out_ready;
            held = {out, co, err};
            accepted = in_valid && in_ready;
            if (accepted) q.push_back(model(cmd, in1, in2));
            @(posedge clk); #1;
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                cmd = 4'($urandom_range(0, 12));
                in1 = pick();
                in2 = pick();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 200 && q.size() > 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                e = q.pop_front();
                outs++;
                tests++;
                if ({out, co, err} !== e) begin
                    fails++; $display("FAIL rnd_drain@%0d: got out=%h co=%b err=%b required %h %b %b",
                                      cyc, out, co, err, e.out, e.co, e.err);
                end
            end
        end
        tests++;
        if (q.size() != 0 || outs < 20) begin
            fails++; $display("FAIL rnd_complete: got %0d pending, %0d results required 0 pending, >=20 results", q.size(), outs);
        end
    endtask

    initial begin
        kill = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
        cmd = 4'd0; in1 = 64'd0; in2 = 64'd0; sel4 = 1'b0;
        test_reset();
        test_add_sub();
        test_mul(1'b0);
        test_mul(1'b1);
        test_back_to_back();
        test_illegal();
        test_kill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
